// File: rtl/mfp_sevenseg_pkg.sv
// Shared definitions for the seven-segment write path: register-select
// encoding, peripheral register addresses, sel-to-address mapping and the
// arbiter FSM state type.
package mfp_sevenseg_pkg;

  // Register-select encoding carried on req_sel
  localparam logic [1:0] SEL_DE    = 2'd0;
  localparam logic [1:0] SEL_DV7_4 = 2'd1;
  localparam logic [1:0] SEL_DV3_0 = 2'd2;
  localparam logic [1:0] SEL_DP    = 2'd3;

  // Seven-segment peripheral register addresses
  localparam logic [31:0] SEVENSEG_DE_ADDR    = 32'h1F70_0000;
  localparam logic [31:0] SEVENSEG_DV7_4_ADDR = 32'h1F70_0004;
  localparam logic [31:0] SEVENSEG_DV3_0_ADDR = 32'h1F70_0008;
  localparam logic [31:0] SEVENSEG_DP_ADDR    = 32'h1F70_000C;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  // Translate a register select into the peripheral bus address
  function automatic logic [31:0] sevenseg_addr(input logic [1:0] sel);
    logic [31:0] addr;
    case (sel)
      SEL_DE:    addr = SEVENSEG_DE_ADDR;
      SEL_DV7_4: addr = SEVENSEG_DV7_4_ADDR;
      SEL_DV3_0: addr = SEVENSEG_DV3_0_ADDR;
      SEL_DP:    addr = SEVENSEG_DP_ADDR;
      default:   addr = SEVENSEG_DE_ADDR;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/mfp_sevenseg_rr_pick.sv
// Rotating-priority picker: the first set request found when searching
// upward from ptr (with wrap-around) wins. ptr must be below N_REQ.
module mfp_sevenseg_rr_pick
  import mfp_sevenseg_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic [N_REQ-1:0] grant,
  output logic [2:0]       idx,
  output logic             any
);

  logic [3:0] cand_s;
  logic [2:0] hit_idx_s;
  logic       hit_s;

  // Walk the search order backwards so the earliest candidate overwrites later ones
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = 3'd0;
    cand_s    = 4'd0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand_s = {1'b0, ptr} + 4'(k);
      if (cand_s >= 4'(N_REQ)) begin
        cand_s = cand_s - 4'(N_REQ);
      end else begin
        cand_s = cand_s;
      end
      for (int j = 0; j < N_REQ; j++) begin
        if (req[j] && (cand_s == 4'(j))) begin
          hit_s     = 1'b1;
          hit_idx_s = 3'(j);
        end else begin
          hit_s     = hit_s;
          hit_idx_s = hit_idx_s;
        end
      end
    end
  end

  // Expand the winning index into a one-hot grant
  always_comb begin
    grant = '0;
    for (int j = 0; j < N_REQ; j++) begin
      grant[j] = hit_s && (hit_idx_s == 3'(j));
    end
  end

  assign idx = hit_idx_s;
  assign any = hit_s;

endmodule

// File: rtl/mfp_sevenseg_write_arbiter.sv
// Round-robin arbiter turning single-register write requests into the
// seven-segment peripheral's address-phase / data-phase sequence.
// Optional feature macro: SEVENSEG_ARB_LOCK_EN (grant lock for multi-word writes).
module mfp_sevenseg_write_arbiter
  import mfp_sevenseg_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [2*N_REQ-1:0]    req_sel,
  input  logic [32*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]      req_lock,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  HSEL,
  output logic [31:0]           HADDR,
  output logic [31:0]           HWDATA,
  output logic                  busy,
  output logic [2:0]            grant_id
);

  arb_state_t        state_r;
  logic [2:0]        rr_ptr_r;
  logic [2:0]        grant_id_r;
  logic [31:0]       data_r;
  logic [N_REQ-1:0]  pick_req_s;
  logic [N_REQ-1:0]  grant_s;
  logic [2:0]        win_idx_s;
  logic              any_s;
  logic [1:0]        win_sel_s;
  logic [31:0]       win_data_s;
  logic [2:0]        next_ptr_s;

`ifdef SEVENSEG_ARB_LOCK_EN
  logic              lock_hold_r;
  logic              win_lock_s;
  logic              holder_valid_s;

  // A held lock restricts the picker to the holder while it keeps requesting
  always_comb begin
    holder_valid_s = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_valid[i] && (rr_ptr_r == 3'(i))) begin
        holder_valid_s = 1'b1;
      end else begin
        holder_valid_s = holder_valid_s;
      end
    end
    if (lock_hold_r && holder_valid_s) begin
      pick_req_s = '0;
      for (int i = 0; i < N_REQ; i++) begin
        pick_req_s[i] = (rr_ptr_r == 3'(i));
      end
    end else begin
      pick_req_s = req_valid;
    end
  end
`else
  logic              unused_lock_s;
  assign unused_lock_s = ^req_lock;
  assign pick_req_s    = req_valid;
`endif

  mfp_sevenseg_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (pick_req_s),
    .ptr   (rr_ptr_r),
    .grant (grant_s),
    .idx   (win_idx_s),
    .any   (any_s)
  );

  // Steer the winning requester's select, data and lock onto the shared path
  always_comb begin
    win_sel_s  = 2'd0;
    win_data_s = 32'd0;
`ifdef SEVENSEG_ARB_LOCK_EN
    win_lock_s = 1'b0;
`endif
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_s[i]) begin
        win_sel_s  = req_sel[2*i +: 2];
        win_data_s = req_data[32*i +: 32];
`ifdef SEVENSEG_ARB_LOCK_EN
        win_lock_s = req_lock[i];
`endif
      end else begin
        win_sel_s  = win_sel_s;
        win_data_s = win_data_s;
      end
    end
  end

  assign next_ptr_s = (win_idx_s == 3'(N_REQ - 1)) ? 3'd0 : (win_idx_s + 3'd1);

  // Arbitration FSM; the address is mapped at acceptance so HADDR is valid in the ADDR cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      rr_ptr_r   <= 3'd0;
      grant_id_r <= 3'd0;
      data_r     <= 32'd0;
      HSEL       <= 1'b0;
      HADDR      <= 32'd0;
      HWDATA     <= 32'd0;
`ifdef SEVENSEG_ARB_LOCK_EN
      lock_hold_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            grant_id_r <= win_idx_s;
            data_r     <= win_data_s;
            HSEL       <= 1'b1;
            HADDR      <= sevenseg_addr(win_sel_s);
            state_r    <= ST_ADDR;
`ifdef SEVENSEG_ARB_LOCK_EN
            lock_hold_r <= win_lock_s;
            rr_ptr_r    <= win_lock_s ? win_idx_s : next_ptr_s;
`else
            rr_ptr_r   <= next_ptr_s;
`endif
          end else begin
            // Nothing valid, so the lock holder (if any) has withdrawn
`ifdef SEVENSEG_ARB_LOCK_EN
            lock_hold_r <= 1'b0;
`endif
            state_r <= ST_IDLE;
          end
        end
        ST_ADDR: begin
          HSEL    <= 1'b0;
          HADDR   <= 32'd0;
          HWDATA  <= data_r;
          state_r <= ST_DATA;
        end
        ST_DATA: begin
          state_r <= ST_IDLE;
        end
        default: begin
          HSEL    <= 1'b0;
          HADDR   <= 32'd0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = ((state_r == ST_IDLE) && !reset) ? grant_s : '0;
  assign busy      = (state_r != ST_IDLE);
  assign grant_id  = grant_id_r;

endmodule

// File: tb/tb_mfp_sevenseg_write_arbiter.sv
// Scoreboard bench for mfp_sevenseg_write_arbiter: directed requests are
// queued per requester, expected writes are pushed in hand-derived order,
// and a negedge monitor checks each address/data phase as it appears.
module tb_mfp_sevenseg_write_arbiter;
  import mfp_sevenseg_pkg::*;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [2*N-1:0]  req_sel;
  logic [32*N-1:0] req_data;
  logic [N-1:0]    req_lock;
  logic [N-1:0]    req_ready;
  logic            HSEL;
  logic [31:0]     HADDR;
  logic [31:0]     HWDATA;
  logic            busy;
  logic [2:0]      grant_id;

  always #5 clk = ~clk;

  mfp_sevenseg_write_arbiter #(.N_REQ(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_sel   (req_sel),
    .req_data  (req_data),
    .req_lock  (req_lock),
    .req_ready (req_ready),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HWDATA    (HWDATA),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  typedef struct packed {
    logic [2:0]  id;
    logic [31:0] addr;
    logic [31:0] data;
    logic        abort;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // per-requester pending writes
  logic [1:0]  psel  [N][8];
  logic [31:0] pdata [N][8];
  logic        plock [N][8];
  int          head [N];
  int          cnt  [N];
  logic [N-1:0] en;
  logic        rst_cmd;
  logic [N-1:0] last_rdy;
  int          step_n = 0;
  int          last_acc = -1;
  logic        spacing_on = 1'b0;

  logic [1:0]  mon_phase = 2'd0;
  exp_t        cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] exp_addr(input logic [1:0] s);
    case (s)
      2'd0:    return SEVENSEG_DE_ADDR;
      2'd1:    return SEVENSEG_DV7_4_ADDR;
      2'd2:    return SEVENSEG_DV3_0_ADDR;
      default: return SEVENSEG_DP_ADDR;
    endcase
  endfunction

  task automatic push_exp(input int id, input logic [1:0] s, input logic [31:0] d, input logic ab);
    exp_t e;
    e.id = 3'(id);
    e.addr = exp_addr(s);
    e.data = d;
    e.abort = ab;
    exp_q.push_back(e);
  endtask

  task automatic add_req(input int i, input logic [1:0] s, input logic [31:0] d, input logic lk);
    psel[i][cnt[i]]  = s;
    pdata[i][cnt[i]] = d;
    plock[i][cnt[i]] = lk;
    cnt[i]++;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      cnt[i] = 0;
    end
    en = '1;
  endtask

  function automatic logic pending();
    logic p = 1'b0;
    for (int i = 0; i < N; i++) if (en[i] && head[i] < cnt[i]) p = 1'b1;
    return p;
  endfunction

  // One clock: drive at negedge, sample ready before the edge, retire accepted requests
  task automatic step();
    @(negedge clk);
    reset = rst_cmd;
    for (int i = 0; i < N; i++) begin
      if (head[i] < cnt[i]) begin
        req_valid[i]      = en[i];
        req_sel[2*i +: 2] = psel[i][head[i]];
        req_data[32*i +: 32] = pdata[i][head[i]];
        req_lock[i]       = plock[i][head[i]];
      end else begin
        req_valid[i] = 1'b0;
        req_lock[i]  = 1'b0;
      end
    end
    #2;
    last_rdy = req_ready;
    check("ready_onehot0", 32'($onehot0(last_rdy)), 32'd1);
    if (last_rdy != '0) check("ready_only_idle", 32'(busy), 32'd0);
    @(posedge clk);
    for (int i = 0; i < N; i++) if (last_rdy[i]) head[i]++;
    if (last_rdy != '0) begin
      if (spacing_on && last_acc >= 0) check("accept_spacing", 32'(step_n - last_acc), 32'd3);
      last_acc = step_n;
    end
    step_n++;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || mon_phase != 2'd0 || pending()) && n < 200) begin
      step();
      n++;
    end
    check("drain_done", 32'(n < 200), 32'd1);
    step();
    step();
  endtask

  task automatic do_reset();
    rst_cmd = 1'b1;
    clear_reqs();
    step();
    step();
    rst_cmd = 1'b0;
  endtask

  // Monitor: pop an expected write on each address phase and check the data phase that follows
  always @(negedge clk) begin
    case (mon_phase)
      2'd1: begin
        check("hwdata", HWDATA, cur.data);
        check("hsel_data_phase", 32'(HSEL), 32'd0);
        check("haddr_data_phase", HADDR, 32'd0);
        check("busy_data_phase", 32'(busy), 32'd1);
        mon_phase <= 2'd2;
      end
      2'd2: begin
        check("busy_after_write", 32'(busy), 32'd0);
        mon_phase <= 2'd0;
      end
      2'd3: begin
        check("abort_hsel", 32'(HSEL), 32'd0);
        check("abort_haddr", HADDR, 32'd0);
        check("abort_hwdata", HWDATA, 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_grant_id", 32'(grant_id), 32'd0);
        mon_phase <= 2'd0;
      end
      default: ;
    endcase
    if (HSEL === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_hsel: HSEL=1 grant_id=%0d HADDR=%h, no write expected", grant_id, HADDR);
      end else begin
        check("grant_id", 32'(grant_id), 32'(exp_q[0].id));
        check("haddr", HADDR, exp_q[0].addr);
        check("busy_addr_phase", 32'(busy), 32'd1);
        cur <= exp_q[0];
        mon_phase <= exp_q[0].abort ? 2'd3 : 2'd1;
        exp_q.delete(0);
      end
    end
  end

  initial begin
    reset = 1'b1;
    rst_cmd = 1'b1;
    req_valid = '0;
    req_sel = '0;
    req_data = '0;
    req_lock = '0;
    clear_reqs();

    // reset state, with requester 2 already requesting (its write is the single-request case)
    add_req(2, 2'd2, 32'h1234_5678, 1'b0);
    push_exp(2, 2'd2, 32'h1234_5678, 1'b0);
    repeat (3) step();
    check("ready_in_reset", 32'(last_rdy), 32'd0);
    #1;
    check("rst_hsel", 32'(HSEL), 32'd0);
    check("rst_haddr", HADDR, 32'd0);
    check("rst_hwdata", HWDATA, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    rst_cmd = 1'b0;
    step();
    check("single_ready", 32'(last_rdy), 32'b0100);
    drain();

    // all four valid continuously: strict rotation, accepts 3 cycles apart
    do_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) begin
        add_req(i, 2'(i + k), 32'hA000_0000 + 32'(i * 16 + k), 1'b0);
        push_exp(i, 2'(i + k), 32'hA000_0000 + 32'(i * 16 + k), 1'b0);
      end
    end
    spacing_on = 1'b1;
    last_acc = -1;
    drain();
    spacing_on = 1'b0;

    // requester 1 withdraws before it is granted
    do_reset();
    add_req(0, 2'd0, 32'h0000_00D0, 1'b0);
    add_req(1, 2'd1, 32'h0000_00D1, 1'b0);
    add_req(2, 2'd3, 32'h0000_00D2, 1'b0);
    push_exp(0, 2'd0, 32'h0000_00D0, 1'b0);
    push_exp(2, 2'd3, 32'h0000_00D2, 1'b0);
    step();
    en[1] = 1'b0;
    drain();
    check("req1_never_served", 32'(head[1]), 32'd0);
    clear_reqs();

    // reset during the ADDR cycle aborts the write (HWDATA holds D2 beforehand)
    add_req(3, 2'd1, 32'h0000_0BAD, 1'b0);
    push_exp(3, 2'd1, 32'h0000_0BAD, 1'b1);
    step();
    check("abort_accept_ready", 32'(last_rdy), 32'b1000);
    rst_cmd = 1'b1;
    step();
    rst_cmd = 1'b0;
    repeat (4) step();
    #1;
    check("no_data_phase_hwdata", HWDATA, 32'd0);
    check("abort_exp_consumed", 32'(exp_q.size()), 32'd0);

    // requester 0 locks for two writes while requester 3 also waits
    do_reset();
    add_req(0, 2'd1, 32'h0000_0011, 1'b1);
    add_req(0, 2'd2, 32'h0000_0022, 1'b0);
    add_req(3, 2'd0, 32'h0000_0033, 1'b0);
`ifdef SEVENSEG_ARB_LOCK_EN
    push_exp(0, 2'd1, 32'h0000_0011, 1'b0);
    push_exp(0, 2'd2, 32'h0000_0022, 1'b0);
    push_exp(3, 2'd0, 32'h0000_0033, 1'b0);
`else
    push_exp(0, 2'd1, 32'h0000_0011, 1'b0);
    push_exp(3, 2'd0, 32'h0000_0033, 1'b0);
    push_exp(0, 2'd2, 32'h0000_0022, 1'b0);
`endif
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
